// File: rtl/kat_adc_pkg.sv
// Shared QDR readback types and the 36->32 word unpack.
// Parity option: KAT_ADC_READBACK_PARITY_CHECK_EN.
package kat_adc_pkg;

    localparam int QDR_WORD_W = 36;
    localparam int RB_WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rb_state_e;

    // Each 9-bit lane carries one pad bit on top of a data byte.
    function automatic logic [RB_WORD_W-1:0] qdr_unpack(
        input logic [QDR_WORD_W-1:0] w
    );
        return {w[34:27], w[25:18], w[16:9], w[7:0]};
    endfunction

    function automatic logic qdr_pad_set(input logic [QDR_WORD_W-1:0] w);
        return w[35] | w[26] | w[17] | w[8];
    endfunction

endpackage

// File: rtl/kat_adc_rb_fifo.sv
// First-word fall-through FIFO for readback samples.
// Exposes its fill count for credit accounting upstream.
module kat_adc_rb_fifo
    import kat_adc_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [RB_WORD_W-1:0]        wdata,
    input  logic                        pop,
    output logic [RB_WORD_W-1:0]        rdata,
    output logic                        valid,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [RB_WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kat_adc_readback.sv
// QDR snapshot readback into a credit-limited 32-bit word FIFO.
// Option: KAT_ADC_READBACK_PARITY_CHECK_EN counts nonzero pad bits.
module kat_adc_readback
    import kat_adc_pkg::*;
#(
    parameter int QDR_SIZE   = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [QDR_SIZE-1:0]   start_addr,
    input  logic [QDR_SIZE-1:0]   length,
    input  logic                  qdr_phy_ready,
    input  logic                  qdr_cal_fail,
    input  logic                  qdr_ack,
    input  logic [QDR_WORD_W-1:0] qdr_din,
    output logic [31:0]           qdr_address,
    output logic                  qdr_rd_en,
    output logic                  qdr_wr_en,
    output logic [3:0]            qdr_be,
    output logic [RB_WORD_W-1:0]  rb_data,
    output logic                  rb_valid,
    input  logic                  rb_pop,
    output logic [31:0]           status
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = QDR_SIZE + 1;

    rb_state_e state;
    rb_state_e state_nx;

    logic                 start_q;
    logic                 start_qq;
    logic                 start_rise;
    logic [QDR_SIZE-1:0]  addr;
    logic [RW-1:0]        remaining;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          inflight;
    logic                 pipe_vld;
    logic [RB_WORD_W-1:0] pipe_data;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [15:0]          par_cnt;
    logic                 ack_ok;
    logic                 ack_bad;
    logic                 credit;
    logic                 issue;
    logic                 launch;
    logic                 launch_fail;
    logic                 finish;

    assign qdr_wr_en  = 1'b0;
    assign qdr_be     = 4'b1111;
    assign start_rise = start_q & ~start_qq;
    assign ack_ok     = qdr_ack & (outstanding != '0);
    assign ack_bad    = qdr_ack & (outstanding == '0);

    // The ack pipeline register holds a word that is neither
    // outstanding nor queued yet, so it must consume credit too.
    assign inflight = (CW+1)'(fifo_count) + (CW+1)'(outstanding)
                    + (CW+1)'(pipe_vld);
    assign credit   = inflight < (CW+1)'(FIFO_DEPTH);

    assign status = {par_cnt, 12'b0, err, done, busy, rb_valid};

    always_comb begin
        state_nx    = state;
        issue       = 1'b0;
        launch      = 1'b0;
        launch_fail = 1'b0;
        finish      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    if (qdr_phy_ready && !qdr_cal_fail) begin
                        launch   = 1'b1;
                        state_nx = ST_ISSUE;
                    end else begin
                        launch_fail = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_nx = ST_DRAIN;
                end else if (credit) begin
                    issue = 1'b1;
                    if (remaining == RW'(1)) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding == '0 && !pipe_vld) begin
                    finish   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            start_qq <= 1'b0;
        end else begin
            state    <= state_nx;
            start_q  <= start;
            start_qq <= start_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            remaining   <= '0;
            qdr_rd_en   <= 1'b0;
            qdr_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            qdr_rd_en <= issue;
            if (launch) begin
                addr      <= start_addr;
                remaining <= (length == '0) ? {1'b1, {QDR_SIZE{1'b0}}}
                                            : {1'b0, length};
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
            end
            if (issue) begin
                qdr_address <= {{(32-QDR_SIZE){1'b0}}, addr};
                addr        <= addr + QDR_SIZE'(1);
                remaining   <= remaining - RW'(1);
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (launch_fail || ack_bad) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            pipe_vld    <= 1'b0;
            pipe_data   <= '0;
        end else begin
            unique case ({issue, ack_ok})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            pipe_vld <= ack_ok;
            if (ack_ok) begin
                pipe_data <= qdr_unpack(qdr_din);
            end
        end
    end

`ifdef KAT_ADC_READBACK_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_cnt <= '0;
        end else if (launch) begin
            par_cnt <= '0;
        end else if (ack_ok && qdr_pad_set(qdr_din) && par_cnt != 16'hFFFF) begin
            par_cnt <= par_cnt + 16'd1;
        end
    end
`else
    logic pad_unused;
    assign pad_unused = qdr_pad_set(qdr_din);
    assign par_cnt    = '0;
`endif

    kat_adc_rb_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_vld),
        .wdata (pipe_data),
        .pop   (rb_pop),
        .rdata (rb_data),
        .valid (rb_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_kat_adc_readback.sv
// Self-checking bench for kat_adc_readback with a QDR responder model.
// Build with KAT_ADC_READBACK_PARITY_CHECK_EN to check the pad counter.
module tb_kat_adc_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] start_addr;
    logic [11:0] length;
    logic        qdr_phy_ready;
    logic        qdr_cal_fail;
    logic        qdr_ack;
    logic [35:0] qdr_din;
    logic [31:0] qdr_address;
    logic        qdr_rd_en;
    logic        qdr_wr_en;
    logic [3:0]  qdr_be;
    logic [31:0] rb_data;
    logic        rb_valid;
    logic        rb_pop;
    logic [31:0] status;

    always #5 clk = ~clk;

    kat_adc_readback dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .start_addr    (start_addr),
        .length        (length),
        .qdr_phy_ready (qdr_phy_ready),
        .qdr_cal_fail  (qdr_cal_fail),
        .qdr_ack       (qdr_ack),
        .qdr_din       (qdr_din),
        .qdr_address   (qdr_address),
        .qdr_rd_en     (qdr_rd_en),
        .qdr_wr_en     (qdr_wr_en),
        .qdr_be        (qdr_be),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .rb_pop        (rb_pop),
        .status        (status)
    );

    localparam logic [35:0] PAD_MASK = 36'h8_0402_0100;

    typedef struct {
        logic [11:0] sa;
        logic [11:0] len;
        int          lat;
        int          pm;
        int          exp_n;
        logic [11:0] exp_first;
        logic [11:0] exp_last;
        int          exp_span;
    } vec_t;

    vec_t        vecs [6];
    logic [35:0] mem [4096];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          issued, popped, lat, pmode, cur_len;
    int          abort_at = 0;
    int          pop_req = 0;
    int          spur_req = 0;
    int          first_cyc, last_cyc;
    logic [11:0] cur_sa, first_addr, last_addr;
    int          pend_addr [$];
    int          pend_due [$];

    // Byte k of the sample is bits [9k+7:9k] of the QDR word.
    function automatic logic [31:0] model_unpack(input logic [35:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = w[9*k +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock: observe reads, pops and credit, then drive acks.
    task automatic tick();
        logic [11:0] exp_a;
        @(negedge clk);
        cyc++;
        if (qdr_rd_en) begin
            exp_a = 12'(int'(cur_sa) + issued);
            check("read_in_range", 32'(issued < cur_len), 32'd1);
            check("read_addr", qdr_address, {20'b0, exp_a});
            pend_addr.push_back(int'(qdr_address[11:0]));
            pend_due.push_back(cyc + lat);
            if (issued == 0) begin
                first_cyc  = cyc;
                first_addr = qdr_address[11:0];
            end
            last_cyc  = cyc;
            last_addr = qdr_address[11:0];
            issued++;
        end
        if (pop_req > 0) begin
            rb_pop = 1'b1;
            pop_req--;
        end else if (pmode == 0) begin
            rb_pop = 1'b0;
        end else if (pmode == 1) begin
            rb_pop = 1'b1;
        end else begin
            rb_pop = 1'($urandom_range(0, 1));
        end
        if (rb_valid && rb_pop) begin
            check("pop_in_range", 32'(popped < cur_len), 32'd1);
            check("rb_data", rb_data,
                  model_unpack(mem[(int'(cur_sa) + popped) % 4096]));
            popped++;
        end
        if (rst && issued != popped) begin
            check("credit", 32'(issued - popped <= 16), 32'd1);
        end
        qdr_ack = 1'b0;
        qdr_din = '0;
        if (spur_req > 0) begin
            qdr_ack = 1'b1;
            qdr_din = {4'($urandom), 32'($urandom)};
            spur_req--;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            qdr_ack = 1'b1;
            qdr_din = mem[pend_addr[0]];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        abort = (abort_at != 0) && (issued >= abort_at);
    endtask

    task automatic new_run(input logic [11:0] sa, input logic [11:0] len,
                           input int l, input int pm);
        cur_sa     = sa;
        cur_len    = (len == 12'd0) ? 4096 : int'(len);
        lat        = l;
        pmode      = pm;
        issued     = 0;
        popped     = 0;
        first_cyc  = 0;
        last_cyc   = 0;
        start_addr = sa;
        length     = len;
        start      = 1'b1;
        repeat (3) tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(status[2] && !status[1] && pend_due.size() == 0 &&
                 (pmode == 0 || !rb_valid)) && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        vecs[0] = '{12'h010, 12'd8,  5, 1, 8,    12'h010, 12'h017, 7};
        vecs[1] = '{12'hFFE, 12'd4,  3, 1, 4,    12'hFFE, 12'h001, 3};
        vecs[2] = '{12'h123, 12'd20, 1, 2, 20,   12'h123, 12'h136, -1};
        vecs[3] = '{12'h000, 12'd1,  2, 1, 1,    12'h000, 12'h000, 0};
        vecs[4] = '{12'hFF0, 12'd33, 7, 2, 33,   12'hFF0, 12'h010, -1};
        vecs[5] = '{12'h800, 12'd0,  2, 1, 4096, 12'h800, 12'h7FF, -1};

        for (int i = 0; i < 4096; i++) begin
            mem[i] = {4'($urandom), 32'($urandom)} & ~PAD_MASK;
        end

        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        length = '0;
        qdr_phy_ready = 1'b1;
        qdr_cal_fail = 1'b0;
        qdr_ack = 1'b0;
        qdr_din = '0;
        rb_pop = 1'b0;
        pmode = 0;
        lat = 1;
        cur_sa = '0;
        cur_len = 0;
        issued = 0;
        popped = 0;
        repeat (3) tick();
        check("rst_rd_en", 32'(qdr_rd_en), 32'd0);
        check("rst_address", qdr_address, 32'd0);
        check("rst_rb_valid", 32'(rb_valid), 32'd0);
        check("rst_rb_data", rb_data, 32'd0);
        check("rst_status", status, 32'd0);
        check("wr_en_tied", 32'(qdr_wr_en), 32'd0);
        check("be_tied", 32'(qdr_be), 32'hF);
        rst = 1'b1;
        repeat (2) tick();
        check("post_rst_status", status, 32'd0);

        for (int v = 0; v < 6; v++) begin
            new_run(vecs[v].sa, vecs[v].len, vecs[v].lat, vecs[v].pm);
            wait_done(6000);
            check("vec_issued", 32'(issued), 32'(vecs[v].exp_n));
            check("vec_popped", 32'(popped), 32'(vecs[v].exp_n));
            check("vec_first", 32'(first_addr), 32'(vecs[v].exp_first));
            check("vec_last", 32'(last_addr), 32'(vecs[v].exp_last));
            check("vec_done_busy_err", status[3:1], 32'b010);
            if (vecs[v].exp_span >= 0) begin
                check("vec_span", 32'(last_cyc - first_cyc),
                      32'(vecs[v].exp_span));
            end
        end

        new_run(12'h100, 12'd64, 8, 0);
        repeat (60) tick();
        check("stall_issued", 32'(issued), 32'd16);
        check("stall_busy", 32'(status[1]), 32'd1);
        check("stall_valid", 32'(rb_valid), 32'd1);
        pop_req = 1;
        repeat (30) tick();
        check("stall_pop1", 32'(popped), 32'd1);
        check("stall_one_more", 32'(issued), 32'd17);
        pmode = 1;
        wait_done(3000);
        check("stall_total", 32'(issued), 32'd64);
        check("stall_popped", 32'(popped), 32'd64);

        abort_at = 5;
        new_run(12'h200, 12'd20, 6, 1);
        wait_done(2000);
        check("abort_issued", 32'(issued), 32'd5);
        check("abort_popped", 32'(popped), 32'd5);
        check("abort_done", 32'(status[2]), 32'd1);
        abort_at = 0;
        tick();

        qdr_phy_ready = 1'b0;
        new_run(12'h050, 12'd4, 2, 1);
        repeat (10) tick();
        check("phy_no_read", 32'(issued), 32'd0);
        check("phy_err", 32'(status[3]), 32'd1);
        check("phy_busy", 32'(status[1]), 32'd0);
        qdr_phy_ready = 1'b1;

        mem[12'h300] = 36'h8_0000_0000;
        mem[12'h301] = 36'h8_0000_0000;
        new_run(12'h300, 12'd2, 3, 1);
        wait_done(500);
        check("par_popped", 32'(popped), 32'd2);
        check("par_err_clr", 32'(status[3]), 32'd0);
`ifdef KAT_ADC_READBACK_PARITY_CHECK_EN
        check("par_count", 32'(status[31:16]), 32'd2);
`else
        check("par_count", 32'(status[31:16]), 32'd0);
`endif

        spur_req = 1;
        repeat (5) tick();
        check("spur_err", 32'(status[3]), 32'd1);
        check("spur_dropped", 32'(rb_valid), 32'd0);

        for (int r = 0; r < 6; r++) begin
            int rl;
            rl = $urandom_range(1, 40);
            new_run(12'($urandom_range(0, 4095)), 12'(rl),
                    $urandom_range(1, 10), 2);
            wait_done(3000);
            check("rnd_issued", 32'(issued), 32'(rl));
            check("rnd_popped", 32'(popped), 32'(rl));
            check("rnd_status", status[3:1], 32'b010);
        end

        new_run(12'h400, 12'd30, 4, 0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(qdr_rd_en), 32'd0);
        check("mid_rst_valid", 32'(rb_valid), 32'd0);
        check("mid_rst_status", status, 32'd0);
        pend_addr.delete();
        pend_due.delete();
        cur_len = 0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", status, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kat_adc_readback.md
# kat_adc_readback

Reads a captured snapshot back out of one QDR buffer and presents it to the CPU register interface as a 32-bit word FIFO. It sits directly downstream of the ADC capture/write engine on the same QDR port, after capture completes. It streams `length` consecutive 36-bit QDR words from `start_addr`, strips the four padding bits, and queues the 32-bit samples behind a credit-limited read pipeline. The queue never overflows regardless of QDR read latency.

## Interface
- `QDR_SIZE`, 12, QDR word-address width; buffer holds 2^QDR_SIZE words
- `FIFO_DEPTH`, 16, output FIFO depth in words; power of two, ≥4
- `clk` in 1: system clock, shared with capture engine and QDR controller
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: level from control register; rising edge launches readback
- `abort` in 1: level; while high, no new reads issue
- `start_addr` in QDR_SIZE: first QDR word address
- `length` in QDR_SIZE: word count; 0 means 2^QDR_SIZE
- `qdr_phy_ready`, `qdr_cal_fail` in 1 each: QDR controller status
- `qdr_ack` in 1: read data valid on `qdr_din`; one per issued read, in order
- `qdr_din` in 36: read data
- `qdr_address` out 32: read address, zero-extended
- `qdr_rd_en` out 1: one-cycle read request per word
- `qdr_wr_en` out 1: tied 0
- `qdr_be` out 4: tied 4'b1111
- `rb_data` out 32: FIFO head word, first-word fall-through
- `rb_valid` out 1: FIFO not empty
- `rb_pop` in 1: consume head word; ignored when `rb_valid`=0
- `status` out 32: {parity_err_count[15:0], 12'b0, err, done, busy, rb_valid}

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: on `start` rising edge (registered edge detect, as in capture control):
  - If `qdr_phy_ready`=1 and `qdr_cal_fail`=0: load addr=`start_addr`, remaining=`length` (0→2^QDR_SIZE), clear `done`/`err`/parity count, go to ISSUE.
  - Otherwise set sticky `err` and stay in IDLE.
- ISSUE: issue a read when credit allows, i.e. fifo_count + outstanding < FIFO_DEPTH and `abort`=0. Each issue increments addr modulo 2^QDR_SIZE (wraps), decrements remaining, and increments outstanding. Go to DRAIN when the last read issues or `abort`=1.
- DRAIN: wait until outstanding=0, then set `done` and go to IDLE.
- Each `qdr_ack` decrements outstanding. Ack and issue in the same cycle leave outstanding unchanged.
- Data packing: `rb_data`={din[34:27],din[25:18],din[16:9],din[7:0]}.
- Ack with outstanding=0 is a protocol error: set `err` and drop the word. The FIFO is never written beyond its capacity.
- `start` edge while busy is ignored.
- Words already in the FIFO survive `done` and `abort`, and remain poppable until consumed or a new start. A new start does not flush the FIFO.
- Async reset: state=IDLE; counters, FIFO pointers, `busy`/`done`/`err` cleared. Reset mid-read drops all in-flight data.

## Timing
- Reset values:
  - `qdr_rd_en`=0, `qdr_address`=0
  - `rb_valid`=0, `rb_data`=0
  - `status`=0
- `qdr_rd_en` and `qdr_address` are registered and driven 2 cycles after the `start` rising edge is sampled. Peak rate is 1 read per cycle.
- Ack→FIFO write: 1 cycle (registered). `rb_valid` rises the following cycle, so ack→`rb_valid` = 2 cycles.
- Pop at head with `rb_valid`=1: next word appears the next cycle. Simultaneous push and pop leaves the count unchanged.
- `busy` is high from the cycle after the start edge until the cycle `done` sets.

## Configuration
- `KAT_ADC_READBACK_PARITY_CHECK_EN`:
  - Defined: each acked word with any of din[35],din[26],din[17],din[8] nonzero increments a saturating 16-bit `parity_err_count`. The capture engine writes these bits as 0.
  - Undefined: these bits are ignored and the count reads 0.

## Structure
- Shared package `kat_adc_pkg` holds:
  - state enum
  - `QDR_WORD_W`=36
  - the 36→32 unpack function, shared with the capture engine's pack
- Sub-module `kat_adc_rb_fifo`: synchronous FWFT FIFO, parameter FIFO_DEPTH, exposes count.

## Test plan
- start_addr=0x010, length=8, ack latency 5, `rb_pop` held 1 → 8 reads at addresses 0x010–0x017 on consecutive cycles; `rb_data` in order; `done`=1, `busy`=0.
- start_addr=0xFFE, length=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- length=64, `rb_pop`=0, ack latency 8 → issues stop at 16 outstanding+queued; no overflow. Popping one word allows exactly one more read.
- `qdr_phy_ready`=0 at start edge → no `qdr_rd_en`, `err`=1, `busy` stays 0.
- abort asserted after 5 issues with latency 6 → exactly 5 words arrive; then `done`=1.
- Macro defined, acked din=36'h8_0000_0000 twice → `parity_err_count`=2; `rb_data`=0.
